// File: rtl/spi_fpmul_system_pkg.sv
// Shared constants and the bfloat16 field layout for the SPI multiplier slice.
package spi_fpmul_system_pkg;
  localparam int          BF16_BIAS        = 127;
  localparam logic [15:0] BF16_QNAN        = 16'h7FC0;
  localparam logic [15:0] BF16_INF         = 16'h7F80;
  localparam int          FRAME_WRITE_BITS = 32;
  localparam int          WORD_BITS        = 16;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bf16_t;
endpackage

// File: rtl/spi_fpmul_system_bf16_mul.sv
// Combinational bfloat16 multiplier: subnormals flush to zero, round to nearest even.
module bf16_mul
  import spi_fpmul_system_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  bf16_t w_a;
  bf16_t w_b;
  logic               w_sign;
  logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [15:0]        w_prod;
  logic signed [9:0]  w_exp_sum, w_exp_n, w_exp_r;
  logic [6:0]         w_mant;
  logic               w_guard, w_sticky, w_round_up;
  logic [7:0]         w_mant_r;

  assign w_a      = a;
  assign w_b      = b;
  assign w_sign   = w_a.sign ^ w_b.sign;
  assign w_a_zero = (w_a.exp == 8'h00);
  assign w_b_zero = (w_b.exp == 8'h00);
  assign w_a_inf  = (w_a.exp == 8'hFF) && (w_a.man == 7'h00);
  assign w_b_inf  = (w_b.exp == 8'hFF) && (w_b.man == 7'h00);
  assign w_a_nan  = (w_a.exp == 8'hFF) && (w_a.man != 7'h00);
  assign w_b_nan  = (w_b.exp == 8'hFF) && (w_b.man != 7'h00);

  always_comb begin
    w_prod    = {1'b1, w_a.man} * {1'b1, w_b.man};
    w_exp_sum = $signed({2'b00, w_a.exp}) + $signed({2'b00, w_b.exp}) - 10'(BF16_BIAS);
    // Product of two [1,2) significands lies in [1,4); bit 15 marks the [2,4) half.
    if (w_prod[15]) begin
      w_mant   = w_prod[14:8];
      w_guard  = w_prod[7];
      w_sticky = |w_prod[6:0];
      w_exp_n  = w_exp_sum + 10'sd1;
    end else begin
      w_mant   = w_prod[13:7];
      w_guard  = w_prod[6];
      w_sticky = |w_prod[5:0];
      w_exp_n  = w_exp_sum;
    end
    w_round_up = w_guard & (w_sticky | w_mant[0]);
    w_mant_r   = {1'b0, w_mant} + {7'b0, w_round_up};
    w_exp_r    = w_exp_n + $signed({9'b0, w_mant_r[7]});

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      y = BF16_QNAN;
    else if (w_a_inf || w_b_inf)
      y = BF16_INF | {w_sign, 15'h0000};
    else if (w_a_zero || w_b_zero)
      y = {w_sign, 15'h0000};
    else if (w_exp_r >= 10'sd255)
      y = BF16_INF | {w_sign, 15'h0000};
    else if (w_exp_r <= 10'sd0)
      y = {w_sign, 15'h0000};
    else
      y = {w_sign, w_exp_r[7:0], w_mant_r[6:0]};
  end
endmodule

// File: rtl/spi_fpmul_system.sv
// SPI mode-0 slave: a 32-bit write frame loads two bf16 operands, a read frame returns their product.
module spi_fpmul_system
  import spi_fpmul_system_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic mosi,
  output logic miso,
  input  logic cs
);
  logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync, r_cs_sync;
  logic                   r_sck_d, r_cs_d;
  logic [31:0]            r_rx;
  logic [WORD_BITS-1:0]   r_tx, r_x1, r_x2, r_result;
  logic [5:0]             r_cnt;
  logic                   r_start;

  logic                   w_sck, w_mosi, w_cs, w_sck_rise, w_cs_rise, w_bit;
  logic [31:0]            w_rx_next;
  logic [5:0]             w_cnt_next;
  logic [WORD_BITS-1:0]   w_y;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_cs_rise  = w_cs & ~r_cs_d;
  // An sck edge coinciding with the cs release still counts as the frame's last bit.
  assign w_bit      = w_sck_rise & (~w_cs | w_cs_rise);
  assign w_rx_next  = w_bit ? {r_rx[30:0], w_mosi} : r_rx;
  assign w_cnt_next = (w_bit && r_cnt != 6'd63) ? r_cnt + 6'd1 : r_cnt;

  bf16_mul u_mul (
    .a (r_x1),
    .b (r_x2),
    .y (w_y)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_cnt       <= '0;
      r_x1        <= '0;
      r_x2        <= '0;
      r_result    <= '0;
      r_start     <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs;
      r_rx        <= w_rx_next;
      r_cnt       <= w_cs ? 6'd0 : w_cnt_next;
      r_start     <= 1'b0;
      if (w_cs_rise && w_cnt_next == 6'(FRAME_WRITE_BITS)) begin
        r_x1    <= w_rx_next[31:16];
        r_x2    <= w_rx_next[15:0];
        r_start <= 1'b1;
      end
      if (r_start)
        r_result <= w_y;
      if (w_cs)
        r_tx <= r_result;
      else if (w_sck_rise)
        r_tx <= {r_tx[14:0], 1'b0};
    end
  end

  // Raw cs gating puts the MSB on miso as soon as the master selects us.
  assign miso = cs ? 1'b0 : r_tx[15];
endmodule

// File: tb/tb_spi_fpmul_system.sv
// Table-driven bench with a result scoreboard for the SPI bf16 multiplier.
module tb_spi_fpmul_system;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sck = 1'b0;
  logic mosi = 1'b0;
  logic cs = 1'b1;
  logic miso;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] q_exp[$];
  logic [15:0] model = 16'h0000;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    string       name;
  } vec_t;

  vec_t vecs[$];

  spi_fpmul_system #(.SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .sck  (sck),
    .mosi (mosi),
    .miso (miso),
    .cs   (cs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Mode-0 master: sck period 40 ns; miso sampled just before each rising edge.
  task automatic spi_xfer(input int nbits, input logic [63:0] dout, input bit cs_with_last,
                          output logic [15:0] din);
    din = 16'h0000;
    cs = 1'b0;
    #20;
    for (int i = 0; i < nbits; i++) begin
      mosi = dout[nbits-1-i];
      #20;
      din = {din[14:0], miso};
      sck = 1'b1;
      if (cs_with_last && i == nbits - 1) cs = 1'b1;
      #20;
      sck = 1'b0;
    end
    mosi = 1'b0;
    if (!cs_with_last) begin
      #20;
      cs = 1'b1;
    end
    #100;
  endtask

  task automatic write_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp,
                          input bit cs_with_last);
    logic [15:0] junk;
    spi_xfer(32, {32'h0, a, b}, cs_with_last, junk);
    q_exp.push_back(exp);
  endtask

  task automatic read_op(input string name);
    logic [15:0] got;
    spi_xfer(16, 64'h0, 1'b0, got);
    if (q_exp.size() > 0) model = q_exp.pop_front();
    check(name, got, model);
    check({name, "_miso_idle"}, {15'h0, miso}, 16'h0000);
  endtask

  initial begin
    logic [15:0] junk;
    vecs.push_back('{16'h4040, 16'h4000, 16'h40C0, "3x2"});
    vecs.push_back('{16'hBFC0, 16'h4000, 16'hC040, "neg1p5x2"});
    vecs.push_back('{16'h3F80, 16'h3F80, 16'h3F80, "1x1"});
    vecs.push_back('{16'h0000, 16'h4040, 16'h0000, "0x3"});
    vecs.push_back('{16'h7F00, 16'h7F00, 16'h7F80, "overflow"});
    vecs.push_back('{16'h7F80, 16'h0000, 16'h7FC0, "infx0"});
    vecs.push_back('{16'h7FC1, 16'h4000, 16'h7FC0, "nan"});
    vecs.push_back('{16'h3FC1, 16'h3FC1, 16'h4012, "round_up"});
    vecs.push_back('{16'h3F81, 16'h3F81, 16'h3F82, "round_down"});
    vecs.push_back('{16'h0080, 16'h0080, 16'h0000, "underflow"});
    vecs.push_back('{16'hFF80, 16'h4000, 16'hFF80, "neg_inf"});
    vecs.push_back('{16'h0040, 16'h4000, 16'h0000, "subnormal_flush"});

    #30;
    rst = 1'b1;
    #50;
    check("reset_miso_idle", {15'h0, miso}, 16'h0000);
    read_op("reset_result");

    foreach (vecs[i]) begin
      write_op(vecs[i].a, vecs[i].b, vecs[i].y, 1'b0);
      read_op(vecs[i].name);
    end

    // cs released on the same edge as the 32nd sck rise
    write_op(16'h3F80, 16'h4040, 16'h4040, 1'b1);
    read_op("cs_with_last_bit");

    write_op(16'h4040, 16'h4000, 16'h40C0, 1'b0);
    read_op("pre_short");
    spi_xfer(20, 64'hABCDE, 1'b0, junk);
    read_op("after_short");
    spi_xfer(40, 64'h3F80_3F80_00, 1'b0, junk);
    read_op("after_long");
    read_op("reread");

    // reset in the middle of a write frame
    cs = 1'b0;
    #20;
    for (int i = 0; i < 16; i++) begin
      mosi = i[0];
      #20 sck = 1'b1;
      #20 sck = 1'b0;
    end
    rst = 1'b0;
    #30;
    rst = 1'b1;
    #20;
    cs = 1'b1;
    mosi = 1'b0;
    #100;
    q_exp.delete();
    model = 16'h0000;
    read_op("reset_mid_frame");
    read_op("reset_mid_frame_reread");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_fpmul_system.md
Name: spi_fpmul_system

Overview:
- SPI-slave front end wrapped around a bfloat16 floating-point multiplier (1 sign, 8 exponent bias 127, 7 mantissa bits).
- A write frame on SPI delivers two 16-bit operands, and the block computes their product. A later read frame shifts the 16-bit result out on miso.
- Top level of the accelerator, clocked by the system clock. sck, mosi and cs are asynchronous inputs.

Parameters:
- SYNC_STAGES, 2, synchronizer depth applied identically to sck, mosi and cs.

Ports:
- clk  in  1  system clock. Must be at least 4x the sck frequency.
- rst  in  1  reset, synchronous to clk, active-low.
- sck  in  1  SPI clock, mode 0, idle low.
- mosi  in  1  SPI data in. MSB first; sampled on sck rising edge.
- miso  out  1  SPI data out. MSB first; valid before each sck rising edge.
- cs  in  1  chip select, active-low, frames a transaction.

Behaviour:
- Reset (rst=0 at a clk edge) clears all state: operands, result register (0x0000), shift registers, bit counter and synchronizers.
- Reset mid-frame aborts the frame, so no operand or result update occurs.
- Synchronization: sck, mosi and cs each pass through SYNC_STAGES flops. Edge detection (rise/fall) is done on the synchronized sck and cs against one extra delayed copy. Equal depth on all three keeps their relative ordering.
- Frame: begins on the synchronized cs falling edge and ends on the synchronized cs rising edge. While synchronized cs is high, the bit counter (6 bits, saturating at 63) is held at 0.
- RX: on each synchronized sck rising edge with synchronized cs low:
  - rx_shift (32 bits) shifts left, inserting synchronized mosi.
  - The bit counter increments.
- Frame end with bit counter == 32: x1 = rx_shift[31:16] (first word), x2 = rx_shift[15:0]. A one-cycle start pulse is issued.
- Any other bit count at frame end leaves operands and result unchanged. This covers read frames (16 bits) and short or long frames.
- Multiply: combinational bf16 multiply of registered x1 and x2. The result register is loaded on the clk after start. Total latency from frame end is 2 clk cycles.
- TX: while synchronized cs is high, tx_shift (16 bits) is continuously loaded with the result register.
- TX with synchronized cs low: on each synchronized sck rising edge (after the master has sampled), tx_shift shifts left with 0 fill.
- miso = cs ? 0 : tx_shift[15]. It is gated by raw cs so the MSB is valid immediately at cs falling. No tri-state is used.
- Multiply rules:
  - sign = s1 ^ s2.
  - Exponent field 0 (zero or subnormal) is treated as signed zero; subnormals are flushed.
  - Normal operands: product = {1,m1} x {1,m2} (16 bits), exponent = e1 + e2 - 127 in 10-bit signed.
  - If product[15]=1: shift right 1 and increment the exponent.
  - Round to nearest even on the 7-bit mantissa using guard/sticky. A rounding carry renormalizes the result.
  - Final exponent >= 255: result is ±inf (0x7F80 | sign).
  - Final exponent <= 0: result is ±0.
  - Either operand NaN, or inf x 0: result is 0x7FC0.
  - inf x nonzero: result is ±inf.
- Simultaneous events: a sck rising edge in the same cycle as cs_sync rising is processed as a bit before the frame-end evaluation.

Decomposition:
- Shared package: BF16_BIAS=127, BF16_QNAN=16'h7FC0, BF16_INF=16'h7F80, FRAME_WRITE_BITS=32, WORD_BITS=16.
- One sub-module, bf16_mul: purely combinational, inputs a[15:0] and b[15:0], output y[15:0]. It implements all multiply rules above.
- The top holds the synchronizers, the SPI shift/count logic, the operand registers and the result register.

Test Plan:
- Reset with clk 10 ns and sck 40 ns. Write 0x4040, 0x4000 (3.0 x 2.0). Wait 100 ns, then a read frame -> miso yields 0xC0C0? No: yields 0x40C0 (6.0).
- Write 0xBFC0, 0x4000 (-1.5 x 2.0) -> read 0xC040. Then write 0x3F80, 0x3F80 -> read 0x3F80.
- Write 0x0000, 0x4040 -> read 0x0000. Write 0x7F00, 0x7F00 -> read 0x7F80 (overflow to inf).
- Write 0x7F80, 0x0000 -> read 0x7FC0. Write 0x7FC1, 0x4000 -> read 0x7FC0.
- Short frame (20 bits) after a valid 6.0 result -> subsequent read still 0x40C0. Reset asserted mid write frame -> read returns 0x0000.
- Two consecutive reads with no write -> both return the same value. miso stays 0 whenever cs is high.
